// File: rtl/teensy_spi_pkg.sv
// Shared constants and FSM state type for the Teensy SPI process-image slave.
package teensy_spi_pkg;

   localparam int FRAME_BITS_DEFAULT = 512;

   function automatic int cnt_width(input int frame_bits);
      return $clog2(frame_bits + 2);
   endfunction

   localparam int CNT_W = cnt_width(FRAME_BITS_DEFAULT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin with a delayed copy and registered
// rise/fall strobes; dly is the level sampled in the same cycle the strobes fire.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic dly,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;

   assign level = sync_q[STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
         dly    <= RST_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         dly  <= level;
         rise <= level & ~dly;
         fall <= ~level & dly;
      end
   end

endmodule

// File: rtl/spi_slave_teensy.sv
// Mode-0 SPI slave exchanging one FRAME_BITS process image per CS_N frame, fully
// oversampled in CLK. Optional link watchdog built when SPI_WATCHDOG_EN is defined.
module spi_slave_teensy
   import teensy_spi_pkg::*;
#(
   parameter int FRAME_BITS     = FRAME_BITS_DEFAULT,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1200000
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  SPI_SCLK,
   input  logic                  SPI_CS_N,
   input  logic                  SPI_MOSI,
   output logic                  SPI_MISO,
   output logic                  SPI_MISO_OE,
   input  logic [FRAME_BITS-1:0] TX_DATA,
   output logic [FRAME_BITS-1:0] RX_DATA,
   output logic                  RX_VALID,
   output logic                  FRAME_ERR,
   output logic                  BUSY,
   output logic                  LINK_TIMEOUT,
   output spi_state_t            dbg_state
);

   localparam int CW = cnt_width(FRAME_BITS);
   localparam int SW = $clog2(SYNC_STAGES + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
   localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

   logic sclk_rise, sclk_fall, sclk_lvl_unused, sclk_dly_unused;
   logic cs_rise, cs_fall, cs_lvl, cs_dly_unused;
   logic mosi_dly, mosi_lvl_unused, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(CLK), .rst_n(RESET_N), .din(SPI_SCLK),
      .level(sclk_lvl_unused), .dly(sclk_dly_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(CLK), .rst_n(RESET_N), .din(SPI_CS_N),
      .level(cs_lvl), .dly(cs_dly_unused), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(CLK), .rst_n(RESET_N), .din(SPI_MOSI),
      .level(mosi_lvl_unused), .dly(mosi_dly), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   spi_state_t            state;
   logic [FRAME_BITS-1:0] tx_sr;
   logic [FRAME_BITS-1:0] rx_sr;
   logic [CW-1:0]         bit_cnt;
   logic [SW-1:0]         settle_cnt;
   logic                  settled;
   logic                  armed;
   logic                  commit;

   // The synchronizer chain holds reset values, not pin samples, until it has
   // been clocked SYNC_STAGES times; only then may CS_N high arm the slave.
   assign settled   = (settle_cnt == SW'(SYNC_STAGES));
   assign commit    = (state == CHECK) && (bit_cnt == CNT_FULL);
   assign dbg_state = state;

   // RX_VALID: single-cycle strobe, RX_DATA holds the new image from that cycle on;
   // there is no back-pressure, the consumer must take it in that cycle.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         tx_sr       <= '0;
         rx_sr       <= '0;
         bit_cnt     <= '0;
         settle_cnt  <= '0;
         armed       <= 1'b0;
         RX_DATA     <= '0;
         RX_VALID    <= 1'b0;
         FRAME_ERR   <= 1'b0;
         BUSY        <= 1'b0;
         SPI_MISO_OE <= 1'b0;
         SPI_MISO    <= 1'b0;
      end else begin
         RX_VALID  <= 1'b0;
         FRAME_ERR <= 1'b0;
         if (!settled) settle_cnt <= settle_cnt + 1'b1;
         if (settled && cs_lvl) armed <= 1'b1;

         case (state)
            IDLE: begin
               if (armed && cs_fall) begin
                  tx_sr       <= TX_DATA;
                  bit_cnt     <= '0;
                  SPI_MISO    <= TX_DATA[0];
                  SPI_MISO_OE <= 1'b1;
                  BUSY        <= 1'b1;
                  state       <= SHIFT;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  SPI_MISO    <= 1'b0;
                  SPI_MISO_OE <= 1'b0;
                  BUSY        <= 1'b0;
                  state       <= CHECK;
               end else begin
                  if (sclk_rise) begin
                     rx_sr <= {mosi_dly, rx_sr[FRAME_BITS-1:1]};
                     if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
                  end
                  if (sclk_fall) begin
                     tx_sr    <= tx_sr >> 1;
                     SPI_MISO <= tx_sr[1];
                  end
               end
            end
            CHECK: begin
               if (commit) begin
                  RX_DATA  <= rx_sr;
                  RX_VALID <= 1'b1;
               end else begin
                  FRAME_ERR <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_cnt;

   // Reloads on the commit edge itself so LINK_TIMEOUT is already low in the RX_VALID cycle.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wd_cnt <= WW'(TIMEOUT_CYCLES);
      end else if (commit) begin
         wd_cnt <= WW'(TIMEOUT_CYCLES);
      end else if (wd_cnt != '0) begin
         wd_cnt <= wd_cnt - 1'b1;
      end
   end

   assign LINK_TIMEOUT = (wd_cnt == '0);
`else
   localparam int timeout_unused = TIMEOUT_CYCLES;
   assign LINK_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_teensy.sv
// Directed bench for spi_slave_teensy: a Teensy-side driver plays frames, a
// monitor pops expected RX_VALID/FRAME_ERR events from a queue and compares.
module tb_spi_slave_teensy;
   import teensy_spi_pkg::*;

   localparam int FB = 512;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          SPI_SCLK, SPI_CS_N, SPI_MOSI;
   logic          SPI_MISO, SPI_MISO_OE;
   logic [FB-1:0] TX_DATA, RX_DATA;
   logic          RX_VALID, FRAME_ERR, BUSY, LINK_TIMEOUT;
   spi_state_t    dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected event queue: bit 512 = 1 for RX_VALID, 0 for FRAME_ERR; low bits = RX_DATA then.
   logic [FB:0]   exp_q[$];
   logic [FB:0]   ev;
   logic [FB-1:0] prev_rx = '0;
   logic          rst_q   = 1'b0;

   localparam logic [FB-1:0] TXC = {8{64'hDEAD_BEEF_0123_4567}};

   spi_slave_teensy #(.FRAME_BITS(FB), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1000)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .SPI_SCLK(SPI_SCLK), .SPI_CS_N(SPI_CS_N),
      .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE),
      .TX_DATA(TX_DATA), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR),
      .BUSY(BUSY), .LINK_TIMEOUT(LINK_TIMEOUT), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- helpers ----------------
   function automatic void check(input string name, input logic [519:0] act, input logic [519:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Bytes sent MSB-first: wire bit 8k+j carries bit (7-j) of byte k.
   function automatic logic [519:0] wire_bytes(input logic [7:0] b, input int nbytes);
      logic [519:0] w;
      w = '0;
      for (int k = 0; k < nbytes; k++)
         for (int j = 0; j < 8; j++)
            w[8*k+j] = b[7-j];
      return w;
   endfunction

   function automatic logic [519:0] low_mask(input int n);
      logic [519:0] m;
      m = '0;
      for (int i = 0; i < n; i++) m[i] = 1'b1;
      return m;
   endfunction

   // ---------------- driver ----------------
   task automatic run_frame(input string name, input logic [519:0] mosi_bits, input int nbits,
                            input logic [FB-1:0] tx, input logic chk, input int rst_at);
      logic [519:0] miso_bits;
      logic         oe_ok;
      miso_bits = '0;
      oe_ok     = 1'b1;
      TX_DATA   = tx;
      @(negedge CLK);
      if (chk) oe_ok &= (SPI_MISO_OE == 1'b0) && (BUSY == 1'b0);
      SPI_CS_N = 1'b0;
      repeat (6) @(negedge CLK);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            RESET_N = 1'b0;
            repeat (3) @(negedge CLK);
            check({name, "_rx_in_reset"}, RX_DATA, '0);
            RESET_N = 1'b1;
         end
         SPI_MOSI = mosi_bits[i];
         repeat (4) @(negedge CLK);
         miso_bits[i] = SPI_MISO;
         if (chk) oe_ok &= (SPI_MISO_OE == 1'b1) && (BUSY == 1'b1);
         SPI_SCLK = 1'b1;
         repeat (4) @(negedge CLK);
         SPI_SCLK = 1'b0;
      end
      SPI_MOSI = 1'b0;
      repeat (6) @(negedge CLK);
      SPI_CS_N = 1'b1;
      repeat (12) @(negedge CLK);
      if (chk) begin
         oe_ok &= (SPI_MISO_OE == 1'b0) && (BUSY == 1'b0);
         check({name, "_miso"}, miso_bits & low_mask(nbits), {8'b0, tx} & low_mask(nbits));
         check({name, "_oe_busy"}, {519'b0, oe_ok}, 520'd1);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge CLK) begin
      if (RESET_N && rst_q && (RX_DATA !== prev_rx))
         check("rx_data_stable", {519'b0, RX_VALID}, 520'd1);
      prev_rx = RX_DATA;
      rst_q   = RESET_N;
      if (RESET_N && (RX_VALID || FRAME_ERR)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {518'b0, RX_VALID, FRAME_ERR}, '0);
         end else begin
            ev = exp_q.pop_front();
            check("event_kind", {518'b0, RX_VALID, FRAME_ERR}, {518'b0, ev[FB], ~ev[FB]});
            check("rx_data", {8'b0, RX_DATA}, {8'b0, ev[FB-1:0]});
`ifdef SPI_WATCHDOG_EN
            if (RX_VALID) check("wd_clear_on_valid", {519'b0, LINK_TIMEOUT}, '0);
            if (FRAME_ERR) check("wd_hold_on_err", {519'b0, LINK_TIMEOUT}, 520'd1);
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      RESET_N  = 1'b0;
      SPI_SCLK = 1'b0;
      SPI_CS_N = 1'b1;
      SPI_MOSI = 1'b0;
      TX_DATA  = '0;
      repeat (5) @(negedge CLK);
      check("rst_outputs", {514'b0, RX_VALID, FRAME_ERR, BUSY, SPI_MISO_OE, SPI_MISO, LINK_TIMEOUT}, '0);
      check("rst_rx_data", {8'b0, RX_DATA}, '0);
      check("rst_state", {518'b0, dbg_state}, {518'b0, IDLE});
      RESET_N = 1'b1;

`ifdef SPI_WATCHDOG_EN
      cyc = 0;
      while (!LINK_TIMEOUT && cyc < 2000) begin
         @(posedge CLK);
         #1;
         cyc++;
      end
      check("wd_first_timeout_cycle", 520'(cyc), 520'd1000);
`else
      cyc = 0;
      repeat (1100) begin
         @(posedge CLK);
         cyc++;
      end
      check("link_timeout_tied_low", {519'b0, LINK_TIMEOUT}, '0);
`endif

      // MOSI mapping: 0x01 bytes MSB-first land as 0x80 bytes.
      exp_q.push_back({1'b1, {64{8'h80}}});
      run_frame("mosi_map", wire_bytes(8'h01, 64), 512, '0, 1'b1, -1);

      // MISO mapping: TX_DATA=5 shifts out 1,0,1,0 then zeros; 0x0F bytes land as 0xF0.
      exp_q.push_back({1'b1, {64{8'hF0}}});
      run_frame("miso_map", wire_bytes(8'h0F, 64), 512, 512'h5, 1'b1, -1);

      // Full all-ones frame, then a 100-bit frame that must be rejected.
      exp_q.push_back({1'b1, {FB{1'b1}}});
      run_frame("full_ff", wire_bytes(8'hFF, 64), 512, TXC, 1'b1, -1);
`ifdef SPI_WATCHDOG_EN
      cyc = 0;
      while (!LINK_TIMEOUT && cyc < 2000) begin
         @(negedge CLK);
         cyc++;
      end
      check("wd_rearmed", {519'b0, LINK_TIMEOUT}, 520'd1);
`endif
      exp_q.push_back({1'b0, {FB{1'b1}}});
      run_frame("short", '0, 100, TXC, 1'b1, -1);

      // Overlong 513-bit frame of zeros must not overwrite RX_DATA.
      exp_q.push_back({1'b0, {FB{1'b1}}});
      run_frame("long", '0, 513, 512'h5, 1'b1, -1);

      // Reset at bit 200 with CS_N held low: rest of that frame ignored, next frame accepted.
      run_frame("rst_mid", wire_bytes(8'h55, 64), 512, TXC, 1'b0, 200);
      check("rst_mid_rx_data", {8'b0, RX_DATA}, '0);
      exp_q.push_back({1'b1, {64{8'h48}}});
      run_frame("after_rst", wire_bytes(8'h12, 64), 512, TXC, 1'b1, -1);

      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
         @(negedge CLK);
         cyc++;
      end
      check("events_drained", 520'(exp_q.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
